// File: rtl/sequential_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// start/busy/done handshake; divide-by-zero completes in one cycle with all-ones quotient.
module sequential_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ZERO = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DIVIDEND_W-1:0] dq_q, dq_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [DIVISOR_W-1:0]  p_q, p_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  done_q, done_d;

    logic [DIVISOR_W:0]    p_shift;
    logic                  qbit;
    logic [DIVISOR_W-1:0]  p_next;
    logic [DIVIDEND_W-1:0] dq_next;

    // dq_q shifts dividend bits out of the top while quotient bits enter at the
    // bottom; after DIVIDEND_W steps it holds the quotient. The settled partial
    // remainder is always < divisor, so only its low DIVISOR_W bits are stored.
    always_comb begin
        p_shift = {p_q, dq_q[DIVIDEND_W-1]};
        qbit    = (p_shift >= {1'b0, divisor_q});
        p_next  = qbit ? (p_shift[DIVISOR_W-1:0] - divisor_q) : p_shift[DIVISOR_W-1:0];
        dq_next = {dq_q[DIVIDEND_W-2:0], qbit};
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dq_d        = dq_q;
        divisor_d   = divisor_q;
        p_d         = p_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dq_d      = dividend;
                    divisor_d = divisor;
                    p_d       = '0;
                    count_d   = '0;
                    state_d   = (divisor == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                dq_d    = dq_next;
                p_d     = p_next;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d     = IDLE;
                    quotient_d  = dq_next;
                    remainder_d = p_next;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
            ZERO: begin
                state_d     = IDLE;
                quotient_d  = '1;
                remainder_d = '0;
                dbz_d       = 1'b1;
                done_d      = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dq_q        <= '0;
            divisor_q   <= '0;
            p_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dq_q        <= dq_d;
            divisor_q   <= divisor_d;
            p_q         <= p_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and swept checks for sequential_divider: table of operations run
// back-to-back, plus hand sequences for busy-start, reset mid-run and operand changes.
module tb_sequential_divider;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    sequential_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit scramble,
                          output int lat);
        bit busy_dropped;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_accept", int'(busy), 1);
        lat = 0;
        busy_dropped = 1'b0;
        while (!done && lat < 20) begin
            if (!busy) busy_dropped = 1'b1;
            if (scramble && lat == 3) begin
                dividend = ~a;
                divisor  = b + 4'd1;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", int'(done), 1);
        chk("busy_held", int'(busy_dropped), 0);
        chk("busy_low_at_done", int'(busy), 0);
    endtask

    initial begin
        int lat;
        int prev_done;
        int ndone;
        logic [7:0] m;
        logic [7:0] a;

        tbl[0] = '{8'd6,   4'd2,  8'd3,   4'd0, 1'b0, 8};
        tbl[1] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8};
        tbl[2] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8};
        tbl[3] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};
        tbl[4] = '{8'd15,  4'd5,  8'd3,   4'd0, 1'b0, 8};
        tbl[5] = '{8'd100, 4'd0,  8'hFF,  4'd0, 1'b1, 1};
        tbl[6] = '{8'd9,   4'd4,  8'd2,   4'd1, 1'b0, 8};
        tbl[7] = '{8'd7,   4'd9,  8'd0,   4'd7, 1'b0, 8};
        tbl[8] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0, 8};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #22;
        chk("rst_quotient",  int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz",       int'(div_by_zero), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_done",      int'(done), 0);
        #13 reset = 1'b0;
        @(posedge clk); #1;

        // Table ops issued back-to-back: each start is raised in the previous done cycle.
        prev_done = 0;
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, 1'b0, lat);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_quotient", i), int'(quotient), int'(tbl[i].q));
            chk($sformatf("v%0d_remainder", i), int'(remainder), int'(tbl[i].r));
            chk($sformatf("v%0d_dbz", i), int'(div_by_zero), int'(tbl[i].z));
            if (i > 0) chk($sformatf("v%0d_spacing", i), cyc - prev_done, tbl[i].lat + 1);
            prev_done = cyc;
        end

        // Operands changed mid-run must not affect the result.
        run_op(8'd255, 4'd15, 1'b1, lat);
        chk("scr_quotient", int'(quotient), 17);
        chk("scr_remainder", int'(remainder), 0);
        run_op(8'd15, 4'd5, 1'b1, lat);
        chk("scr2_quotient", int'(quotient), 3);
        chk("scr2_remainder", int'(remainder), 0);

        // Start pulsed while busy is dropped, not queued.
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("busy_start_dones", ndone, 1);
        chk("busy_start_quotient", int'(quotient), 28);
        chk("busy_start_remainder", int'(remainder), 4);

        // Reset in the middle of a run clears outputs immediately with no done.
        start = 1'b1; dividend = 8'd100; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("midrst_quotient",  int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_busy",      int'(busy), 0);
        chk("midrst_done",      int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("midrst_no_activity", ndone, 0);
        run_op(8'd9, 4'd4, 1'b0, lat);
        chk("postrst_latency", lat, 8);
        chk("postrst_quotient", int'(quotient), 2);
        chk("postrst_remainder", int'(remainder), 1);

        // Zero-divisor op sets the flag; next normal op clears it.
        run_op(8'd100, 4'd0, 1'b0, lat);
        chk("zero_latency", lat, 1);
        chk("zero_dbz", int'(div_by_zero), 1);
        chk("zero_quotient", int'(quotient), 255);

        // Sweep every dividend against every non-zero divisor, dividends in scrambled order.
        m = 8'($urandom_range(0, 255));
        for (int d = 1; d < 16; d++) begin
            for (int n = 0; n < 256; n++) begin
                a = 8'(n) ^ m;
                run_op(a, 4'(d), 1'b0, lat);
                chk($sformatf("sw_%0d_%0d_q", a, d), int'(quotient), int'(a) / d);
                chk($sformatf("sw_%0d_%0d_r", a, d), int'(remainder), int'(a) % d);
                chk($sformatf("sw_%0d_%0d_inv", a, d),
                    ((int'(quotient) * d + int'(remainder)) == int'(a) && int'(remainder) < d) ? 1 : 0, 1);
            end
        end
        chk("sweep_dbz_clear", int'(div_by_zero), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Sequential restoring divider: the inverse operation of the team's 4x4 sequential multiplier. Divides an 8-bit dividend (a multiplier-width product) by a 4-bit divisor, producing one quotient bit per clock. Sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake, so a controller can issue operations back-to-back.

Parameters:
DIVIDEND_W, 8, dividend and quotient width (must be >= DIVISOR_W)
DIVISOR_W, 4, divisor and remainder width

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while idle
dividend  input  DIVIDEND_W  unsigned dividend, captured when start is accepted
divisor  input  DIVISOR_W  unsigned divisor, captured when start is accepted
quotient  output  DIVIDEND_W  unsigned quotient, registered
remainder  output  DIVISOR_W  unsigned remainder, registered
div_by_zero  output  1  set when the last completed operation had divisor==0
busy  output  1  high while an operation is in progress
done  output  1  single-cycle completion pulse

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (asserted at any time, including mid-operation): state=IDLE, quotient=0, remainder=0, div_by_zero=0, busy=0, done=0, and internal counter and partial remainder cleared. An in-flight operation is abandoned, with no done pulse.
- FSM states:
  - IDLE: start=1 at edge k captures the operands and goes to RUN with busy=1. If divisor==0, go to ZERO instead.
  - RUN: performs DIVIDEND_W iterations, one per edge.
  - ZERO: at edge k+1, quotient=all ones, remainder=0, div_by_zero=1, done=1, then return to IDLE.
- Operand capture: dividend and divisor are latched at acceptance. Input changes after that are ignored until the next accepted start.
- Iteration, MSB first:
  - Partial remainder P is DIVISOR_W+1 bits wide.
  - P' = {P[DIVISOR_W-1:0], next dividend bit}.
  - If P' >= divisor, then P = P' - divisor and the quotient bit is 1. Otherwise P = P' and the quotient bit is 0.
  - Arithmetic is unsigned and has no overflow, because the final P < divisor.
- Latency: start accepted at edge k gives done=1 and valid quotient/remainder after edge k+DIVIDEND_W (8 cycles by default). busy is high from edge k until edge k+DIVIDEND_W, then low.
- Outputs: quotient and remainder are updated only at completion. They hold their values until the next completion or reset. div_by_zero is cleared when a non-zero-divisor operation completes.
- done lasts exactly one cycle. The FSM is IDLE in that cycle, so a start asserted during the done cycle is accepted (back-to-back throughput of DIVIDEND_W+1 cycles per op).
- start while busy (RUN or ZERO) is ignored and not queued.
- Held start: a start held high continuously re-triggers at every IDLE cycle.
- Invariant on normal completion: quotient*divisor + remainder == dividend.

Test Plan:
- Reset held for 35 time units, then dividend=6, divisor=2, start for 1 cycle -> busy for 8 cycles, then done pulse; quotient=3, remainder=0, div_by_zero=0.
- dividend=200, divisor=7 -> quotient=28, remainder=4. Immediately after, dividend=255, divisor=1 started in the done cycle -> accepted, quotient=255, remainder=0, completes exactly 9 cycles after the first done.
- dividend=255, divisor=15 -> quotient=17, remainder=0. dividend=15, divisor=5 -> quotient=3, remainder=0. Change the operands mid-RUN -> results unaffected.
- dividend=100, divisor=0 -> done 1 cycle after acceptance, quotient=8'hFF, remainder=0, div_by_zero=1. A next op of 9/4 -> quotient=2, remainder=1, div_by_zero=0.
- Start an op, pulse start again at cycle 3 while busy -> ignored, only one done. Assert reset at cycle 4 of a RUN -> all outputs 0 immediately (asynchronous), no done pulse. A new start after reset completes normally.
- Randomised sweep of all 256x15 non-zero-divisor pairs -> the invariant and remainder < divisor hold for every operation.
